// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration helpers for the parametrised Moore sequence detector.
// The match counter is only built when SEQ_DET_MATCH_COUNT_EN is defined.
package seq_det_pkg;

  localparam logic [3:0] DEFAULT_PATTERN = 4'b1011;
  localparam int         STATE_S0        = 0;

  // Smallest n such that 2**n >= value.
  function automatic int clog2(input int value);
    int n;
    n = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) n = i + 1;
    end
    return n;
  endfunction

  // Bits needed to encode states S0..S(pat_w).
  function automatic int state_w(input int pat_w);
    int w;
    w = clog2(pat_w + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational KMP transition function for the sequence detector.
// Per-state successor tables are computed at elaboration; unused encodings map to S0.
module seq_det_next_state
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  localparam int              SW      = state_w(PAT_W)
) (
  input  logic [SW-1:0] state,
  input  logic          bit_in,
  output logic [SW-1:0] next_state,
  output logic          state_legal
);

  // i-th received pattern bit (0 = first bit on the wire).
  function automatic logic pat_bit(input int i);
    logic [PAT_W-1:0] tmp;
    tmp = PATTERN >> (PAT_W - 1 - i);
    return tmp[0];
  endfunction

  // Longest pattern prefix that is a suffix of (history of state s) followed by b.
  function automatic logic [SW-1:0] kmp_next(input int s, input logic b);
    int   h;
    int   best;
    int   idx;
    logic ok;
    logic cbit;
    h    = (s == PAT_W) ? (OVERLAP ? PAT_W : 0) : s;
    best = STATE_S0;
    for (int k = 1; k <= PAT_W; k++) begin
      ok = (k <= h + 1);
      for (int j = 0; j < k; j++) begin
        idx = h + 1 - k + j;
        if (idx < 0)       cbit = 1'b0;
        else if (idx == h) cbit = b;
        else               cbit = pat_bit(idx);
        if (cbit != pat_bit(j)) ok = 1'b0;
      end
      if (ok) best = k;
    end
    return SW'(best);
  endfunction

  logic [SW-1:0] nxt0_tbl [PAT_W+1];
  logic [SW-1:0] nxt1_tbl [PAT_W+1];

  for (genvar gi = 0; gi <= PAT_W; gi++) begin : g_tbl
    localparam logic [SW-1:0] N0 = kmp_next(gi, 1'b0);
    localparam logic [SW-1:0] N1 = kmp_next(gi, 1'b1);
    assign nxt0_tbl[gi] = N0;
    assign nxt1_tbl[gi] = N1;
  end

  always_comb begin
    next_state  = SW'(STATE_S0);
    state_legal = 1'b0;
    for (int i = 0; i <= PAT_W; i++) begin
      if (state == SW'(i)) begin
        state_legal = 1'b1;
        next_state  = bit_in ? nxt1_tbl[i] : nxt0_tbl[i];
      end
    end
  end

endmodule

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore serial pattern detector with valid qualifier, synchronous clear and
// an optional saturating match counter (enabled by defining SEQ_DET_MATCH_COUNT_EN).
module seq_detector_moore_param
  import seq_det_pkg::*;
#(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = DEFAULT_PATTERN,
  parameter bit               OVERLAP = 1'b1,
  parameter int               CNT_W   = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             sequence_in,
  input  logic             in_valid,
  input  logic             clear,
  output logic             detector_out,
  output logic [CNT_W-1:0] match_count
);

  localparam int            SW     = state_w(PAT_W);
  localparam logic [SW-1:0] S0     = SW'(STATE_S0);
  localparam logic [SW-1:0] DETECT = SW'(PAT_W);

  logic [SW-1:0] state_q;
  logic [SW-1:0] state_d;
  logic [SW-1:0] trans_state;
  logic          state_legal;

  seq_det_next_state #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN),
    .OVERLAP (OVERLAP)
  ) u_next_state (
    .state       (state_q),
    .bit_in      (sequence_in),
    .next_state  (trans_state),
    .state_legal (state_legal)
  );

  // Illegal encodings fall back to S0 even when no bit is accepted.
  always_comb begin
    state_d = state_q;
    if (clear)             state_d = S0;
    else if (!state_legal) state_d = S0;
    else if (in_valid)     state_d = trans_state;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S0;
    else        state_q <= state_d;
  end

  assign detector_out = (state_q == DETECT);

`ifdef SEQ_DET_MATCH_COUNT_EN
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clear)
      count_d = '0;
    else if (in_valid && state_legal && (trans_state == DETECT) && (count_q != {CNT_W{1'b1}}))
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  assign match_count = count_q;
`else
  assign match_count = '0;
`endif

endmodule
